// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_MOV  = 4'd1,
    OP_CMP  = 4'd2,
    OP_TEST = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ADD  = 4'd6,
    OP_ADC  = 4'd7,
    OP_SUB  = 4'd8,
    OP_SBB  = 4'd9,
    OP_MUL  = 4'd10,
    OP_AND  = 4'd11,
    OP_OR   = 4'd12,
    OP_XOR  = 4'd13,
    OP_NOT  = 4'd14,
    OP_CLRF = 4'd15
  } alu_op_e;

  localparam int FLAG_Z = 7;
  localparam int FLAG_S = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_V = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_BUSY = 2'd2,
    DONE     = 2'd3
  } alu_state_e;

  // Assemble the architectural flags byte; the low nibble is always zero.
  function automatic logic [7:0] pack_flags(input logic z, input logic s,
                                            input logic c, input logic v);
    return {z, s, c, v, 4'b0000};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WORD_SIZE cycles.
// done pulses for one cycle when product holds the final value.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int MUL_CNT_W = $clog2(WORD_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   a,
  input  logic [WORD_SIZE-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [2*WORD_SIZE-1:0] product
);

  localparam logic [MUL_CNT_W-1:0] CNT_INIT = WORD_SIZE[MUL_CNT_W-1:0];
  localparam logic [MUL_CNT_W-1:0] CNT_ONE  = {{(MUL_CNT_W-1){1'b0}}, 1'b1};

  logic [2*WORD_SIZE-1:0] acc_q, acc_d;
  logic [2*WORD_SIZE-1:0] mcand_q, mcand_d;
  logic [WORD_SIZE-1:0]   mplier_q, mplier_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state for the iteration: load on start, otherwise add-and-shift while busy.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = {(2*WORD_SIZE){1'b0}};
      mcand_d  = {{WORD_SIZE{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CNT_INIT;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration state registers; reset abandons any product in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {(2*WORD_SIZE){1'b0}};
      mcand_q  <= {(2*WORD_SIZE){1'b0}};
      mplier_q <= {WORD_SIZE{1'b0}};
      cnt_q    <= {MUL_CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready request and response handshakes, an internal
// flags register, and a multi-cycle multiplier for MUL.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int MUL_CNT_W = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           mode_select,
  input  logic [WORD_SIZE-1:0] input_A,
  input  logic [WORD_SIZE-1:0] input_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] output_C,
  output logic [WORD_SIZE-1:0] output_hi,
  output logic [7:0]           flags
);

  localparam logic [WORD_SIZE-1:0] W_VAL = WORD_SIZE[WORD_SIZE-1:0];
  localparam logic [WORD_SIZE-1:0] ZERO  = {WORD_SIZE{1'b0}};

  alu_state_e             state_q, state_d;
  alu_op_e                op_q, op_d;
  logic [WORD_SIZE-1:0]   a_q, a_d, b_q, b_d;
  logic                   cin_q, cin_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]   c_q, c_d, hi_q, hi_d;
  logic [7:0]             flags_q, flags_d;

  logic                   accept_s, is_mul_s, mul_start_s;
  logic                   mul_busy_s, mul_done_s;
  logic [2*WORD_SIZE-1:0] mul_prod_s;

  logic [WORD_SIZE:0]     add_s, sub_s;
  logic                   add_v_s, sub_v_s;
  logic [2*WORD_SIZE-1:0] shl_ext_s, shr_ext_s;
  logic                   shift_big_s, shift_zero_s;
  logic [WORD_SIZE-1:0]   res_s, fsrc_s;
  logic                   wr_res_s, upd_zs_s;
  logic                   z_s, s_s, c_s, v_s;

  alu_mul_iter #(
    .WORD_SIZE(WORD_SIZE),
    .MUL_CNT_W(MUL_CNT_W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_s),
    .a      (input_A),
    .b      (input_B),
    .busy   (mul_busy_s),
    .done   (mul_done_s),
    .product(mul_prod_s)
  );

  assign in_ready    = !rst && !mul_busy_s &&
                       ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept_s    = in_valid && in_ready;
  assign is_mul_s    = (alu_op_e'(mode_select) == OP_MUL);
  assign mul_start_s = accept_s && is_mul_s;

  // Single-cycle datapath evaluated in EXEC on the operands latched at accept.
  always_comb begin
    add_s = {1'b0, a_q} + {1'b0, b_q} + {{WORD_SIZE{1'b0}}, (op_q == OP_ADC) && cin_q};
    sub_s = {1'b0, a_q} - {1'b0, b_q} - {{WORD_SIZE{1'b0}}, (op_q == OP_SBB) && cin_q};
    add_v_s = (a_q[WORD_SIZE-1] == b_q[WORD_SIZE-1]) &&
              (add_s[WORD_SIZE-1] != a_q[WORD_SIZE-1]);
    sub_v_s = (a_q[WORD_SIZE-1] != b_q[WORD_SIZE-1]) &&
              (sub_s[WORD_SIZE-1] != a_q[WORD_SIZE-1]);
    // Carry is the bit just beyond the word after a double-width shift.
    shl_ext_s    = {{WORD_SIZE{1'b0}}, a_q} << b_q;
    shr_ext_s    = {a_q, {WORD_SIZE{1'b0}}} >> b_q;
    shift_big_s  = (b_q > W_VAL);
    shift_zero_s = (b_q == ZERO);

    res_s    = c_q;
    fsrc_s   = c_q;
    wr_res_s = 1'b0;
    upd_zs_s = 1'b0;
    z_s      = flags_q[FLAG_Z];
    s_s      = flags_q[FLAG_S];
    c_s      = flags_q[FLAG_C];
    v_s      = flags_q[FLAG_V];

    case (op_q)
      OP_NOP: begin
        wr_res_s = 1'b0;
      end
      OP_MOV: begin
        res_s    = b_q;
        wr_res_s = 1'b1;
      end
      OP_CMP: begin
        fsrc_s   = sub_s[WORD_SIZE-1:0];
        upd_zs_s = 1'b1;
        c_s      = sub_s[WORD_SIZE];
        v_s      = sub_v_s;
      end
      OP_TEST: begin
        fsrc_s   = a_q & b_q;
        upd_zs_s = 1'b1;
        c_s      = 1'b0;
        v_s      = 1'b0;
      end
      OP_SHL, OP_SHR: begin
        wr_res_s = 1'b1;
        upd_zs_s = 1'b1;
        if (shift_big_s) begin
          res_s = ZERO;
          c_s   = 1'b0;
        end else if (shift_zero_s) begin
          res_s = a_q;
        end else if (op_q == OP_SHL) begin
          res_s = shl_ext_s[WORD_SIZE-1:0];
          c_s   = shl_ext_s[WORD_SIZE];
        end else begin
          res_s = shr_ext_s[2*WORD_SIZE-1:WORD_SIZE];
          c_s   = shr_ext_s[WORD_SIZE-1];
        end
        fsrc_s = res_s;
      end
      OP_ADD, OP_ADC: begin
        res_s    = add_s[WORD_SIZE-1:0];
        fsrc_s   = res_s;
        wr_res_s = 1'b1;
        upd_zs_s = 1'b1;
        c_s      = add_s[WORD_SIZE];
        v_s      = add_v_s;
      end
      OP_SUB, OP_SBB: begin
        res_s    = sub_s[WORD_SIZE-1:0];
        fsrc_s   = res_s;
        wr_res_s = 1'b1;
        upd_zs_s = 1'b1;
        c_s      = sub_s[WORD_SIZE];
        v_s      = sub_v_s;
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (op_q == OP_AND) begin
          res_s = a_q & b_q;
        end else if (op_q == OP_OR) begin
          res_s = a_q | b_q;
        end else begin
          res_s = a_q ^ b_q;
        end
        fsrc_s   = res_s;
        wr_res_s = 1'b1;
        upd_zs_s = 1'b1;
        c_s      = 1'b0;
        v_s      = 1'b0;
      end
      OP_NOT: begin
        res_s    = ~a_q;
        fsrc_s   = res_s;
        wr_res_s = 1'b1;
        upd_zs_s = 1'b1;
      end
      OP_CLRF: begin
        z_s = 1'b0;
        s_s = 1'b0;
        c_s = 1'b0;
        v_s = 1'b0;
      end
      default: begin
        wr_res_s = 1'b0;
      end
    endcase

    if (upd_zs_s) begin
      z_s = (fsrc_s == ZERO);
      s_s = fsrc_s[WORD_SIZE-1];
    end else begin
      z_s = z_s;
    end
  end

  // FSM sequencing, operand capture and result/flags update on out_valid rise.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    hi_d        = hi_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = is_mul_s ? MUL_BUSY : EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        flags_d     = pack_flags(z_s, s_s, c_s, v_s);
        if (wr_res_s) begin
          c_d  = res_s;
          hi_d = ZERO;
        end else begin
          c_d  = c_q;
        end
      end
      MUL_BUSY: begin
        if (mul_done_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          c_d         = mul_prod_s[WORD_SIZE-1:0];
          hi_d        = mul_prod_s[2*WORD_SIZE-1:WORD_SIZE];
          flags_d     = pack_flags(mul_prod_s == {(2*WORD_SIZE){1'b0}},
                                   mul_prod_s[WORD_SIZE-1],
                                   mul_prod_s[2*WORD_SIZE-1:WORD_SIZE] != ZERO,
                                   mul_prod_s[2*WORD_SIZE-1:WORD_SIZE] != ZERO);
        end else begin
          state_d = MUL_BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept_s) begin
            state_d = is_mul_s ? MUL_BUSY : EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (accept_s) begin
      op_d  = alu_op_e'(mode_select);
      a_d   = input_A;
      b_d   = input_B;
      cin_d = flags_q[FLAG_C];
    end else begin
      op_d  = op_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      a_q         <= ZERO;
      b_q         <= ZERO;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= ZERO;
      hi_q        <= ZERO;
      flags_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      hi_q        <= hi_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign output_C  = c_q;
  assign output_hi = hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] mode_select;
  logic [7:0] input_A, input_B, output_C, output_hi, flags;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: result low/high words and flags byte.
  int m_c, m_hi, m_f;

  alu_seq #(.WORD_SIZE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode_select(mode_select), .input_A(input_A), .input_B(input_B),
    .out_valid(out_valid), .out_ready(out_ready), .output_C(output_C),
    .output_hi(output_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Apply one operation to the model using plain integer arithmetic.
  task automatic model_apply(input int op, input int a, input int b);
    int r, full, sr, ci;
    bit wr, zs, zf, sf, cf, vf;
    zf = m_f[7]; sf = m_f[6]; cf = m_f[5]; vf = m_f[4];
    r = 0; wr = 0; zs = 0;
    case (op)
      1: begin r = b; wr = 1; end
      2: begin r = (a - b) & 255; zs = 1; cf = (b > a);
               sr = sx(a) - sx(b); vf = (sr < -128 || sr > 127); end
      3: begin r = a & b; zs = 1; cf = 0; vf = 0; end
      4, 5: begin
        wr = 1; zs = 1;
        if (b == 0) r = a;
        else if (b > 8) begin r = 0; cf = 0; end
        else if (op == 4) begin full = a << b; r = full & 255; cf = (full >> 8) & 1; end
        else begin r = a >> b; cf = (a >> (b - 1)) & 1; end
      end
      6, 7: begin
        ci = (op == 7) ? m_f[5] : 0;
        full = a + b + ci; r = full & 255; cf = (full > 255); wr = 1; zs = 1;
        sr = sx(a) + sx(b) + ci; vf = (sr < -128 || sr > 127);
      end
      8, 9: begin
        ci = (op == 9) ? m_f[5] : 0;
        r = (a - b - ci) & 255; cf = (b + ci > a); wr = 1; zs = 1;
        sr = sx(a) - sx(b) - ci; vf = (sr < -128 || sr > 127);
      end
      10: begin
        full = a * b; m_c = full & 255; m_hi = full >> 8;
        zf = (full == 0); sf = (m_c >> 7) & 1; cf = (m_hi != 0); vf = cf;
      end
      11: begin r = a & b; wr = 1; zs = 1; cf = 0; vf = 0; end
      12: begin r = a | b; wr = 1; zs = 1; cf = 0; vf = 0; end
      13: begin r = a ^ b; wr = 1; zs = 1; cf = 0; vf = 0; end
      14: begin r = (~a) & 255; wr = 1; zs = 1; end
      15: begin zf = 0; sf = 0; cf = 0; vf = 0; end
      default: ;
    endcase
    if (zs) begin zf = (r == 0); sf = (r >> 7) & 1; end
    if (wr) begin m_c = r; m_hi = 0; end
    m_f = {24'd0, zf, sf, cf, vf, 4'b0000};
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_C"}, output_C, m_c);
    check({tag, "_hi"}, output_hi, m_hi);
    check({tag, "_flags"}, flags, m_f);
  endtask

  // Issue one operation, measure accept-to-valid latency, check, then consume.
  task automatic do_op(input int op, input int a, input int b, input int hold);
    int cyc, lat;
    bit busy_ok;
    @(negedge clk);
    mode_select = op[3:0]; input_A = a[7:0]; input_B = b[7:0];
    in_valid = 1'b1; out_ready = (hold == 0);
    #1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    model_apply(op, a, b);
    lat = 0; busy_ok = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 0;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", lat, (op == 10) ? 9 : 1);
    check("busy_in_ready_low", busy_ok, 1);
    check_outputs("op");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check_outputs("hold");
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("consumed", out_valid, 0);
  endtask

  initial begin
    int seen, op, a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode_select = 4'd0; input_A = 8'd0; input_B = 8'd0;
    m_c = 0; m_hi = 0; m_f = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check_outputs("rst");
    rst = 1'b0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed sequence with the known answers.
    do_op(6, 8'h7F, 8'h01, 0);
    check("add_C", output_C, 8'h80); check("add_flags", flags, 8'h50);
    do_op(8, 8'h00, 8'h01, 0);
    check("sub_C", output_C, 8'hFF); check("sub_flags", flags, 8'h60);
    do_op(9, 8'h05, 8'h01, 0);
    check("sbb_C", output_C, 8'h03); check("sbb_flags", flags, 8'h00);
    do_op(10, 8'h10, 8'h20, 0);
    check("mul_C", output_C, 8'h00); check("mul_hi", output_hi, 8'h02);
    check("mul_flags", flags, 8'h30);
    do_op(15, 0, 0, 0);
    do_op(4, 8'h81, 1, 0);
    check("shl1_C", output_C, 8'h02); check("shl1_carry", flags[5], 1);
    do_op(5, 8'h81, 1, 0);
    check("shr1_C", output_C, 8'h40); check("shr1_carry", flags[5], 1);
    do_op(4, 8'h81, 9, 0);
    check("shl9_C", output_C, 8'h00); check("shl9_flags", flags, 8'h80);
    do_op(5, 8'h81, 8, 0);
    check("shr8_carry", flags[5], 1);

    // Backpressure then consume-and-accept on the same edge.
    @(negedge clk);
    mode_select = 4'd6; input_A = 8'h11; input_B = 8'h22; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); model_apply(6, 8'h11, 8'h22);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("bp_valid", out_valid, 1);
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check_outputs("bp");
    end
    mode_select = 4'd13; input_A = 8'hF0; input_B = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    #1; check("bp_release_ready", in_ready, 1);
    @(posedge clk); model_apply(13, 8'hF0, 8'h3C);
    @(negedge clk); in_valid = 1'b0;
    check("xor_not_yet", out_valid, 0);
    @(posedge clk); @(negedge clk);
    check("xor_valid", out_valid, 1);
    check("xor_C", output_C, 8'hCC);
    check_outputs("xor");
    @(posedge clk); @(negedge clk);

    // Reset in the middle of a multiply.
    do_op(6, 8'h7F, 8'h01, 0);
    @(negedge clk);
    mode_select = 4'd10; input_A = 8'h10; input_B = 8'h20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk);
    m_c = 0; m_hi = 0; m_f = 0;
    check("mrst_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 0);
    check_outputs("mrst");
    rst = 1'b0; #1;
    check("mrst_ready_after", in_ready, 1);
    seen = 0;
    repeat (15) begin @(negedge clk); if (out_valid) seen = 1; end
    check("mrst_no_stale", seen, 0);
    check_outputs("mrst_after");

    // Randomised operations with random backpressure.
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = (op == 4 || op == 5) ? $urandom_range(0, 11) : $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = 0;
      do_op(op, a, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
